// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder end of the single-cycle processor's load/store bus. It holds a
//   word-addressed data RAM and a 256-byte MMIO page. The page contains a byte
//   TX FIFO that drains to a peripheral over valid/ready, and a down-counting
//   timer with a sticky expiry flag that drives an interrupt.
// Ports
//   clk        : system clock, all state changes on the rising edge
//   reset      : asynchronous, active-high reset
//   MemWrite   : store strobe from the processor
//   Addr       : byte address (the processor's ALUResult)
//   WriteData  : store data
//   ReadData   : load data, combinational from Addr in the same cycle
//   out_valid  : TX FIFO is non-empty
//   out_data   : FIFO head byte, 8'h00 when the FIFO is empty
//   out_ready  : peripheral accepts the head when out_valid && out_ready
//   timer_irq  : sticky timer-expired flag
module data_mem_responder #(
  parameter int          MEM_DEPTH  = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        timer_irq
);

  localparam int          AW        = $clog2(MEM_DEPTH);
  localparam int          FW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(MEM_DEPTH * 4);
  localparam logic [FW:0] CNT_FULL  = (FW+1)'(FIFO_DEPTH);
  localparam logic [FW:0] CNT_ONE   = (FW+1)'(1);
  localparam logic [FW-1:0] PTR_ONE = FW'(1);

  localparam logic [7:0] REG_STATUS = 8'h00;
  localparam logic [7:0] REG_TXDATA = 8'h04;
  localparam logic [7:0] REG_TIMER  = 8'h08;
  localparam logic [7:0] REG_CTRL   = 8'h0C;

  logic [31:0]   r_mem  [MEM_DEPTH];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [FW-1:0] r_wr_ptr;
  logic [FW-1:0] r_rd_ptr;
  logic [FW:0]   r_count;
  logic          r_overflow;
  logic          r_expired;
  logic [31:0]   r_timer;

  logic          w_ram_hit;
  logic          w_mmio_hit;
  logic [7:0]    w_reg_off;
  logic [AW-1:0] w_ram_idx;
  logic          w_full;
  logic          w_push_req;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_evt;
  logic          w_timer_load;
  logic          w_expire_evt;
  logic          w_ctrl_clr;
  logic [31:0]   w_status;

  // Address decode; the low two address bits are ignored (word access only).
  assign w_ram_hit  = (Addr < RAM_BYTES);
  assign w_mmio_hit = (Addr[31:8] == MMIO_BASE[31:8]);
  assign w_reg_off  = {Addr[7:2], 2'b00};
  assign w_ram_idx  = Addr[AW+1:2];

  assign w_full     = (r_count == CNT_FULL);
  assign out_valid  = (r_count != {(FW+1){1'b0}});
  assign w_pop      = out_valid && out_ready;
  assign w_push_req = MemWrite && w_mmio_hit && (w_reg_off == REG_TXDATA);
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_evt  = w_push_req && w_full && !w_pop;

  assign w_timer_load = MemWrite && w_mmio_hit && (w_reg_off == REG_TIMER);
  assign w_ctrl_clr   = MemWrite && w_mmio_hit && (w_reg_off == REG_CTRL) && WriteData[0];
  // A load in the same cycle as the 1->0 step pre-empts the expiry.
  assign w_expire_evt = !w_timer_load && (r_timer == 32'd1);

  assign out_data  = out_valid ? r_fifo[r_rd_ptr] : 8'h00;
  assign timer_irq = r_expired;

  // Data RAM write port (contents are not reset).
  always_ff @(posedge clk) begin
    if (MemWrite && w_ram_hit) begin
      r_mem[w_ram_idx] <= WriteData;
    end
  end

  // FIFO storage write port (contents are gated by out_valid, so not reset).
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= WriteData[7:0];
    end
  end

  // FIFO pointers, occupancy and overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= {FW{1'b0}};
      r_rd_ptr   <= {FW{1'b0}};
      r_count    <= {(FW+1){1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      // Set beats clear when both happen in one cycle.
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end else if (w_ctrl_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Down-counting timer and sticky expiry flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer   <= 32'h0;
      r_expired <= 1'b0;
    end else begin
      if (w_timer_load) begin
        r_timer <= WriteData;
      end else if (r_timer != 32'h0) begin
        r_timer <= r_timer - 32'd1;
      end
      if (w_expire_evt) begin
        r_expired <= 1'b1;
      end else if (w_ctrl_clr) begin
        r_expired <= 1'b0;
      end
    end
  end

  // STATUS word assembly.
  always_comb begin
    w_status           = 32'h0;
    w_status[0]        = w_full;
    w_status[1]        = !out_valid;
    w_status[2]        = r_expired;
    w_status[3]        = r_overflow;
    w_status[8 +: FW+1] = r_count;
  end

  // Load data mux; unmapped addresses and write-only registers read zero.
  always_comb begin
    ReadData = 32'h0;
    if (w_ram_hit) begin
      ReadData = r_mem[w_ram_idx];
    end else if (w_mmio_hit) begin
      case (w_reg_off)
        REG_STATUS: ReadData = w_status;
        REG_TIMER:  ReadData = r_timer;
        default:    ReadData = 32'h0;
      endcase
    end else begin
      ReadData = 32'h0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder: a table of bus read/write vectors
// followed by hand-written FIFO, timer and reset sequences.
module tb_data_mem_responder;

  localparam logic [31:0] A_STATUS = 32'hFFFF_FF00;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_FF04;
  localparam logic [31:0] A_TIMER  = 32'hFFFF_FF08;
  localparam logic [31:0] A_CTRL   = 32'hFFFF_FF0C;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        timer_irq;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[14];

  data_mem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    Addr      = a;
    WriteData = d;
    step();
    MemWrite  = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    Addr = a;
    #1;
    chk(name, ReadData, exp);
  endtask

  initial begin
    logic [7:0] exp_bytes[8];

    reset     = 1'b1;
    MemWrite  = 1'b0;
    Addr      = 32'h0;
    WriteData = 32'h0;
    out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_data",  {24'h0, out_data},  32'h0);
    chk("rst_timer_irq", {31'h0, timer_irq}, 32'h0);
    rd_chk("rst_status", A_STATUS, 32'h0000_0002);
    reset = 1'b0;
    step();

    // Bus vector table
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0};
    vecs[4]  = '{1'b1, 32'h0000_0400, 32'h1234_5678, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0};
    vecs[6]  = '{1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_00FE, 32'h0,         1'b1, 32'hCAFE_F00D};
    vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h1111_1111};
    vecs[10] = '{1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0};
    vecs[11] = '{1'b0, A_TXDATA,      32'h0,         1'b1, 32'h0};
    vecs[12] = '{1'b0, A_CTRL,        32'h0,         1'b1, 32'h0};
    vecs[13] = '{1'b0, 32'hFFFF_FE00, 32'h0,         1'b1, 32'h0};
    for (int i = 0; i < 14; i++) begin
      MemWrite  = vecs[i].we;
      Addr      = vecs[i].addr;
      WriteData = vecs[i].wdata;
      #1;
      if (vecs[i].chk) begin
        chk($sformatf("vec%0d_rd", i), ReadData, vecs[i].exp_rd);
      end
      step();
    end
    MemWrite = 1'b0;

    // FIFO fill to overflow, then drain in order
    chk("fifo_empty_pre", {31'h0, out_valid}, 32'h0);
    wr(A_TXDATA, 32'h0000_0041);
    chk("fifo_first_valid", {31'h0, out_valid}, 32'h1);
    chk("fifo_first_data",  {24'h0, out_data},  32'h41);
    for (int i = 1; i < 9; i++) begin
      wr(A_TXDATA, 32'h41 + 32'(i));
    end
    rd_chk("fifo_full_status", A_STATUS, 32'h0000_0809);
    chk("fifo_stall_data", {24'h0, out_data}, 32'h41);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_valid", i), {31'h0, out_valid}, 32'h1);
      chk($sformatf("drain%0d_data", i),  {24'h0, out_data},  32'h41 + 32'(i));
      step();
    end
    chk("drain_end_valid", {31'h0, out_valid}, 32'h0);
    chk("drain_end_data",  {24'h0, out_data},  32'h0);
    out_ready = 1'b0;
    rd_chk("ovf_sticky_status", A_STATUS, 32'h0000_000A);
    wr(A_CTRL, 32'h1);
    rd_chk("ovf_cleared_status", A_STATUS, 32'h0000_0002);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      wr(A_TXDATA, 32'h61 + 32'(i));
    end
    rd_chk("pp_full_status", A_STATUS, 32'h0000_0801);
    MemWrite  = 1'b1;
    Addr      = A_TXDATA;
    WriteData = 32'h0000_005A;
    out_ready = 1'b1;
    chk("pp_head", {24'h0, out_data}, 32'h61);
    step();
    MemWrite = 1'b0;
    rd_chk("pp_after_status", A_STATUS, 32'h0000_0801);
    exp_bytes = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h5A};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("pp_drain%0d", i), {24'h0, out_data}, {24'h0, exp_bytes[i]});
      step();
    end
    chk("pp_end_valid", {31'h0, out_valid}, 32'h0);
    out_ready = 1'b0;

    // Timer countdown and sticky expiry
    wr(A_TIMER, 32'h3);
    rd_chk("tmr_loaded", A_TIMER, 32'h3);
    step();
    chk("tmr_2", ReadData, 32'h2);
    chk("tmr_irq_at2", {31'h0, timer_irq}, 32'h0);
    step();
    chk("tmr_1", ReadData, 32'h1);
    chk("tmr_irq_at1", {31'h0, timer_irq}, 32'h0);
    step();
    chk("tmr_0", ReadData, 32'h0);
    chk("tmr_irq_at0", {31'h0, timer_irq}, 32'h1);
    step();
    chk("tmr_stop0", ReadData, 32'h0);
    rd_chk("tmr_status", A_STATUS, 32'h0000_0006);
    wr(A_CTRL, 32'h1);
    chk("tmr_irq_cleared", {31'h0, timer_irq}, 32'h0);
    wr(A_TIMER, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
    end
    chk("tmr_load0_irq", {31'h0, timer_irq}, 32'h0);
    // Load on the 1->0 cycle pre-empts expiry
    wr(A_TIMER, 32'h2);
    step();
    wr(A_TIMER, 32'h7);
    chk("tmr_reload_irq", {31'h0, timer_irq}, 32'h0);
    rd_chk("tmr_reload_val", A_TIMER, 32'h7);
    // Expiry and CTRL clear in the same cycle: set wins
    wr(A_TIMER, 32'h1);
    wr(A_CTRL, 32'h1);
    chk("tmr_set_wins", {31'h0, timer_irq}, 32'h1);

    // Reset asserted with bytes queued
    for (int i = 0; i < 4; i++) begin
      wr(A_TXDATA, 32'h70 + 32'(i));
    end
    chk("mid_valid_pre", {31'h0, out_valid}, 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_data",  {24'h0, out_data},  32'h0);
    chk("mid_rst_irq",   {31'h0, timer_irq}, 32'h0);
    #2;
    reset = 1'b0;
    step();
    rd_chk("post_rst_status", A_STATUS, 32'h0000_0002);
    chk("post_rst_valid", {31'h0, out_valid}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
